scene_ctrl: RTL and testbench

Top-level scene sequencer for the game. It consumes the one-cycle-registered `return`-style request pulses produced by the failure and win screens, the start key from the menu, and the level status from the game engine. It holds the current scene and level, pulses a level-load strobe to the game engine, and selects which screen's 12-bit pixel stream drives the VGA output. It sits directly downstream of the failure screen and between all screen modules and the VGA port.

---
 rtl/scene_ctrl_if.sv | 32 +++
 rtl/scene_ctrl.sv | 95 +++++++++
 tb/tb_scene_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/scene_ctrl_if.sv
// Scene controller signal bundle: screen/engine requests and pixels in,
// scene/level state and the registered VGA pixel out.
interface scene_ctrl_if #(
  parameter int LEVEL_W = 3
);
  logic               valid;
  logic               start_key;
  logic               level_clear;
  logic               level_fail;
  logic               fail_return;
  logic               win_return;
  logic [11:0]        pixel_menu;
  logic [11:0]        pixel_game;
  logic [11:0]        pixel_fail;
  logic [11:0]        pixel_win;
  logic [1:0]         scene;
  logic [LEVEL_W-1:0] level;
  logic               level_load;
  logic [11:0]        vga_rgb;

  modport slave (
    input  valid, start_key, level_clear, level_fail, fail_return, win_return,
           pixel_menu, pixel_game, pixel_fail, pixel_win,
    output scene, level, level_load, vga_rgb
  );

  modport master (
    output valid, start_key, level_clear, level_fail, fail_return, win_return,
           pixel_menu, pixel_game, pixel_fail, pixel_win,
    input  scene, level, level_load, vga_rgb
  );
endinterface

// File: rtl/scene_ctrl.sv
// Game scene sequencer: MENU/PLAY/FAIL/WIN FSM with a post-change input
// lockout, level tracking with load strobe, and the VGA pixel mux.
module scene_ctrl #(
  parameter int NUM_LEVELS     = 5,
  parameter int LEVEL_W        = 3,
  parameter int LOCKOUT_CYCLES = 1000000,
  parameter int LOCK_W         = 20
) (
  input  logic        clk,
  input  logic        rst,
  scene_ctrl_if.slave bus
);
  typedef enum logic [1:0] {MENU = 2'd0, PLAY = 2'd1, FAIL = 2'd2, WIN = 2'd3} scene_e;

  localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LOCK_W-1:0]  LOCK_RELOAD = LOCK_W'(LOCKOUT_CYCLES);

  scene_e             scene_q, scene_n;
  logic [LEVEL_W-1:0] level_q, level_n;
  logic               load_q, load_n;
  logic [LOCK_W-1:0]  lock_q, lock_n;
  logic               start_prev, fret_prev, wret_prev;
  logic               start_edge, fret_edge, wret_edge;
  logic               chg;
  logic [11:0]        vga_q;
  logic [3:0][11:0]   pix;

  assign start_edge = bus.start_key   & ~start_prev;
  assign fret_edge  = bus.fail_return & ~fret_prev;
  assign wret_edge  = bus.win_return  & ~wret_prev;

  assign pix = {bus.pixel_win, bus.pixel_fail, bus.pixel_game, bus.pixel_menu};

  always_comb begin
    scene_n = scene_q;
    level_n = level_q;
    load_n  = 1'b0;
    chg     = 1'b0;
    // Edges seen while locked out are simply dropped; prev still tracks input.
    if (lock_q == '0) begin
      unique case (scene_q)
        MENU: if (start_edge) begin
          scene_n = PLAY; level_n = '0; load_n = 1'b1; chg = 1'b1;
        end
        PLAY: begin
          if (bus.level_fail) begin
            scene_n = FAIL; chg = 1'b1;
          end else if (bus.level_clear) begin
            if (level_q < LAST_LEVEL) begin
              level_n = level_q + LEVEL_W'(1); load_n = 1'b1;
            end else begin
              scene_n = WIN; chg = 1'b1;
            end
          end
        end
        FAIL: if (fret_edge) begin
          scene_n = PLAY; load_n = 1'b1; chg = 1'b1;
        end
        WIN: if (wret_edge) begin
          scene_n = MENU; level_n = '0; chg = 1'b1;
        end
        default: ;
      endcase
    end
    // Level advances inside PLAY deliberately leave the lockout alone.
    lock_n = chg ? LOCK_RELOAD : ((lock_q != '0) ? lock_q - LOCK_W'(1) : lock_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scene_q    <= MENU;
      level_q    <= '0;
      load_q     <= 1'b0;
      lock_q     <= LOCK_RELOAD;
      start_prev <= 1'b0;
      fret_prev  <= 1'b0;
      wret_prev  <= 1'b0;
      vga_q      <= '0;
    end else begin
      scene_q    <= scene_n;
      level_q    <= level_n;
      load_q     <= load_n;
      lock_q     <= lock_n;
      start_prev <= bus.start_key;
      fret_prev  <= bus.fail_return;
      wret_prev  <= bus.win_return;
      vga_q      <= bus.valid ? pix[scene_q] : 12'h000;
    end
  end

  assign bus.scene      = scene_q;
  assign bus.level      = level_q;
  assign bus.level_load = load_q;
  assign bus.vga_rgb    = vga_q;
endmodule

// File: tb/tb_scene_ctrl.sv
// Directed bench for scene_ctrl with a 4-cycle lockout and 5 levels.
module tb_scene_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  localparam logic [11:0] PM = 12'h0A1, PG = 12'h0B2, PF = 12'hF00, PW = 12'h0C3;

  always #5 clk = ~clk;

  scene_ctrl_if #(.LEVEL_W(3)) bus();

  scene_ctrl #(
    .NUM_LEVELS(5), .LEVEL_W(3), .LOCKOUT_CYCLES(4), .LOCK_W(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_key = 1'b1;
    step(); step();
    total++; if (bus.scene !== 2'd0) begin bad++; $display("FAIL reset_scene got %0d exp 0", bus.scene); end
    total++; if (bus.level !== 3'd0) begin bad++; $display("FAIL reset_level got %0d exp 0", bus.level); end
    total++; if (bus.level_load !== 1'b0) begin bad++; $display("FAIL reset_load got %b exp 0", bus.level_load); end
    total++; if (bus.vga_rgb !== 12'h000) begin bad++; $display("FAIL reset_vga got %h exp 000", bus.vga_rgb); end
    rst = 1'b0;
  endtask

  // start held through lockout must never fire; a fresh edge afterwards must
  task automatic test_start_hold();
    int moved = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.scene !== 2'd0) moved++;
    end
    total++; if (moved != 0) begin bad++; $display("FAIL start_held cycles_out_of_menu got %0d exp 0", moved); end
    total++; if (bus.vga_rgb !== PM) begin bad++; $display("FAIL menu_pixel got %h exp %h", bus.vga_rgb, PM); end
    bus.start_key = 1'b0; step();
    bus.start_key = 1'b1; step();
    total++; if (bus.scene !== 2'd1) begin bad++; $display("FAIL start_scene got %0d exp 1", bus.scene); end
    total++; if (bus.level !== 3'd0) begin bad++; $display("FAIL start_level got %0d exp 0", bus.level); end
    total++; if (bus.level_load !== 1'b1) begin bad++; $display("FAIL start_load got %b exp 1", bus.level_load); end
    bus.start_key = 1'b0; step();
    total++; if (bus.level_load !== 1'b0) begin bad++; $display("FAIL start_load_drop got %b exp 0", bus.level_load); end
    total++; if (bus.vga_rgb !== PG) begin bad++; $display("FAIL game_pixel got %h exp %h", bus.vga_rgb, PG); end
    step(); step(); step();
  endtask

  task automatic test_levels();
    for (int i = 1; i <= 4; i++) begin
      bus.level_clear = 1'b1; step();
      total++; if (bus.level !== 3'(i) || bus.level_load !== 1'b1 || bus.scene !== 2'd1) begin
        bad++; $display("FAIL advance_%0d got lvl=%0d load=%b scene=%0d exp lvl=%0d load=1 scene=1",
                        i, bus.level, bus.level_load, bus.scene, i);
      end
      bus.level_clear = 1'b0; step();
      total++; if (bus.level_load !== 1'b0) begin bad++; $display("FAIL advance_load_drop_%0d got %b exp 0", i, bus.level_load); end
    end
    bus.level_clear = 1'b1; step();
    bus.level_clear = 1'b0;
    total++; if (bus.scene !== 2'd3 || bus.level !== 3'd4 || bus.level_load !== 1'b0) begin
      bad++; $display("FAIL final_clear got scene=%0d lvl=%0d load=%b exp scene=3 lvl=4 load=0",
                      bus.scene, bus.level, bus.level_load);
    end
  endtask

  task automatic test_win_return();
    step(); step(); step(); step();
    bus.win_return = 1'b1; step();
    bus.win_return = 1'b0;
    total++; if (bus.scene !== 2'd0 || bus.level !== 3'd0) begin
      bad++; $display("FAIL win_return got scene=%0d lvl=%0d exp scene=0 lvl=0", bus.scene, bus.level);
    end
    step(); step(); step(); step();
    bus.start_key = 1'b1; step();
    bus.start_key = 1'b0;
    total++; if (bus.scene !== 2'd1 || bus.level_load !== 1'b1) begin
      bad++; $display("FAIL restart got scene=%0d load=%b exp scene=1 load=1", bus.scene, bus.level_load);
    end
    step(); step(); step(); step();
    for (int i = 0; i < 2; i++) begin
      bus.level_clear = 1'b1; step();
      bus.level_clear = 1'b0; step();
    end
    total++; if (bus.level !== 3'd2) begin bad++; $display("FAIL reach_level2 got %0d exp 2", bus.level); end
  endtask

  task automatic test_fail_priority();
    bus.level_fail = 1'b1; bus.level_clear = 1'b1; step();
    bus.level_fail = 1'b0; bus.level_clear = 1'b0;
    total++; if (bus.scene !== 2'd2 || bus.level !== 3'd2 || bus.level_load !== 1'b0) begin
      bad++; $display("FAIL fail_priority got scene=%0d lvl=%0d load=%b exp scene=2 lvl=2 load=0",
                      bus.scene, bus.level, bus.level_load);
    end
  endtask

  task automatic test_fail_return();
    int loads = 0;
    logic [1:0] exp_scene;
    step(); step(); step(); step();
    bus.fail_return = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.level_load === 1'b1) loads++;
      if (i == 1) bus.level_fail = 1'b1;
      exp_scene = (i <= 5) ? 2'd1 : 2'd2;
      total++; if (bus.scene !== exp_scene || bus.level !== 3'd2) begin
        bad++; $display("FAIL fail_return_cyc%0d got scene=%0d lvl=%0d exp scene=%0d lvl=2",
                        i, bus.scene, bus.level, exp_scene);
      end
      if (i == 6) begin
        total++; if (bus.vga_rgb !== PG) begin bad++; $display("FAIL change_old_pixel got %h exp %h", bus.vga_rgb, PG); end
      end
      if (i == 7) begin
        total++; if (bus.vga_rgb !== PF) begin bad++; $display("FAIL change_new_pixel got %h exp %h", bus.vga_rgb, PF); end
      end
    end
    bus.fail_return = 1'b0; bus.level_fail = 1'b0;
    total++; if (loads != 1) begin bad++; $display("FAIL fail_return_loads got %0d exp 1", loads); end
  endtask

  task automatic test_pixel();
    bus.valid = 1'b1; step();
    total++; if (bus.vga_rgb !== PF) begin bad++; $display("FAIL pixel_valid got %h exp %h", bus.vga_rgb, PF); end
    bus.valid = 1'b0; step();
    total++; if (bus.vga_rgb !== 12'h000) begin bad++; $display("FAIL pixel_blank got %h exp 000", bus.vga_rgb); end
    bus.valid = 1'b1;
  endtask

  task automatic test_mid_reset();
    bus.fail_return = 1'b1; step();
    bus.fail_return = 1'b0;
    step(); step(); step(); step();
    bus.level_clear = 1'b1; step();
    bus.level_clear = 1'b0; step();
    total++; if (bus.scene !== 2'd1 || bus.level !== 3'd3) begin
      bad++; $display("FAIL pre_reset got scene=%0d lvl=%0d exp scene=1 lvl=3", bus.scene, bus.level);
    end
    rst = 1'b1; bus.level_clear = 1'b1; step();
    rst = 1'b0; bus.level_clear = 1'b0;
    total++; if (bus.scene !== 2'd0 || bus.level !== 3'd0 || bus.level_load !== 1'b0 || bus.vga_rgb !== 12'h000) begin
      bad++; $display("FAIL mid_reset got scene=%0d lvl=%0d load=%b vga=%h exp 0 0 0 000",
                      bus.scene, bus.level, bus.level_load, bus.vga_rgb);
    end
    step();
    bus.start_key = 1'b1; step();
    bus.start_key = 1'b0;
    total++; if (bus.scene !== 2'd0) begin bad++; $display("FAIL lockout_start_a got %0d exp 0", bus.scene); end
    step();
    bus.start_key = 1'b1; step();
    bus.start_key = 1'b0;
    total++; if (bus.scene !== 2'd0) begin bad++; $display("FAIL lockout_start_b got %0d exp 0", bus.scene); end
    step();
    bus.start_key = 1'b1; step();
    bus.start_key = 1'b0;
    total++; if (bus.scene !== 2'd1 || bus.level_load !== 1'b1) begin
      bad++; $display("FAIL post_lockout_start got scene=%0d load=%b exp 1 1", bus.scene, bus.level_load);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.valid = 1'b1;
    bus.start_key = 1'b0; bus.level_clear = 1'b0; bus.level_fail = 1'b0;
    bus.fail_return = 1'b0; bus.win_return = 1'b0;
    bus.pixel_menu = PM; bus.pixel_game = PG; bus.pixel_fail = PF; bus.pixel_win = PW;
    test_reset();
    test_start_hold();
    test_levels();
    test_win_return();
    test_fail_priority();
    test_fail_return();
    test_pixel();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end
endmodule
